glyph_rom_arbiter: RTL and testbench
====================================

Name: glyph_rom_arbiter

Overview:
- Shares one 12-bit-wide glyph dot-matrix ROM between several pixel-pipeline requesters.
- Typical requesters: requester 0 is the falling-character playfield; requester 1 is the fps/score overlay.
- Grants at most one address per clock, tags the request through the ROM read latency and steers the returned row to a per-requester held result register.
- Sits between the VGA-clock pixel logic and the single ROM instance, replacing the duplicated ROM copies.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- AW, 12, ROM address width (glyph code << 4 | row).
- DW, 12, ROM data width (one glyph row).
- ROM_LAT, 1, cycles from rom_addr to valid rom_dout (1..4).

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  arbitration enable; low = no new grants.
- req_valid  in  NUM_REQ  per-requester request; held until granted.
- req_addr  in  NUM_REQ*AW  packed addresses; slot i = bits [i*AW +: AW].
- gnt  out  NUM_REQ  combinational one-hot grant for this cycle.
- rom_addr  out  AW  registered address to the ROM.
- rom_dout  in  DW  ROM read data.
- rsp_valid  out  NUM_REQ  one-cycle pulse: slot i result updated.
- rsp_data  out  NUM_REQ*DW  per-requester held glyph row.
- conflict_cnt  out  16  saturating count of cycles with >1 request pending while en=1.

Behaviour:
- Reset (rst_n=0 at an edge): rom_addr=0, rsp_valid=0, rsp_data=0, conflict_cnt=0, tag pipeline flushed, RR pointer=NUM_REQ-1.
- Reset mid-operation: in-flight reads are discarded; no rsp_valid ever results from a pre-reset grant.
- gnt is zero while rst_n=0.
- Handshake: a request transfers in the cycle where req_valid[i]=1 and gnt[i]=1. Requester keeps req_addr stable until then and may drop req_valid the next cycle.
- gnt is at most one-hot. gnt=0 when en=0 or no req_valid.
- Arbitration, default: fixed priority, lowest index wins.
- Pipeline:
  - Grant cycle t: rom_addr <= winning address at the edge ending t; tag {valid,id} enters a ROM_LAT+1 deep shift register.
  - rom_dout is sampled ROM_LAT cycles after rom_addr changes. At that edge rsp_data slot[id] <= rom_dout.
  - rsp_valid[id]=1 during cycle t+ROM_LAT+2 only.
  - Fixed latency ROM_LAT+2; back-to-back grants give one response per cycle, in grant order.
- No grant cycle: rom_addr holds its value; a bubble tag is inserted; no rsp_valid.
- rsp_data slots not addressed by a returning tag hold their value indefinitely.
- en falling: in-flight tags still complete; only new grants stop.
- conflict_cnt: increments when en=1 and popcount(req_valid)>=2; saturates at 16'hFFFF, no wrap.
- Same address from two requesters: each is granted and returned separately; no merging.
- Widths: popcount and pointer math sized to clog2(NUM_REQ)+1; no truncation warnings.

Optional Feature:
- Macro: GLYPH_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Search starts at (last_granted+1) mod NUM_REQ.
  - The pointer updates only on an actual grant.
  - Any continuously requesting source is granted within NUM_REQ cycles.
- Undefined: fixed priority as above; the pointer register is not built.

Test Plan:
- Reset then single request: req_valid=2'b01, addr0=12'h410 at cycle 0, ROM model returns addr^12'hFFF (ROM_LAT=1) -> gnt=01 in cycle 0, rom_addr=12'h410 in cycle 1, rsp_valid=01 in cycle 3, rsp_data slot0=12'hBEF; slot1 stays 0.
- Contention, fixed priority: both requesting every cycle for 8 cycles, addr0=12'h300, addr1=12'h310 -> gnt=01 all 8 cycles, slot1 never updated, conflict_cnt=8.
- Contention with GLYPH_ARB_ROUND_ROBIN_EN: same stimulus -> gnt alternates 01,10,01,... starting 01; 4 responses per slot; slot1=12'hCEF.
- Back-to-back plus bubble: grants in cycles 0,1 and 3 -> rsp_valid in cycles 3,4 and 6 with matching ids; cycle 5 has rsp_valid=0.
- en deassert and reset mid-flight: grant in cycle 0, en=0 in cycle 1 -> response still in cycle 3, no further gnt. Second run: grant in cycle 0, rst_n=0 in cycle 1 -> no rsp_valid, all outputs 0 after the edge.
- Saturation: preload conflict_cnt near max with both requesting for 65540 cycles -> conflict_cnt=16'hFFFF and remains.

Source files
------------

// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter: shares one glyph dot-matrix ROM between NUM_REQ pixel
// pipeline requesters. One grant per clock, the requester id travels alongside
// the ROM read in a tag pipeline, and the returned row lands in that
// requester's held result slot.
// Optional build macro: GLYPH_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; left undefined, the lowest requester index always wins.
module glyph_rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 12,
    parameter int DW      = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_dout,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [NUM_REQ*DW-1:0] rsp_data,
    output logic [15:0]           conflict_cnt
);
    // Id/popcount/pointer width; one spare bit so ptr+1+k never overflows.
    localparam int PW    = $clog2(NUM_REQ) + 1;
    // Tag is written at the grant edge and consumed at the rom_dout sample edge.
    localparam int DEPTH = ROM_LAT + 1;

    logic                win_valid;
    logic [PW-1:0]       win_id;
    logic [AW-1:0]       win_addr;
    logic [PW-1:0]       req_pop;

    logic [AW-1:0]       rom_addr_reg;
    logic [DEPTH-1:0]    tag_valid_reg;
    logic [PW-1:0]       tag_id_reg [DEPTH];
    logic [NUM_REQ-1:0]  rsp_valid_reg;
    logic [15:0]         conflict_cnt_reg;

`ifdef GLYPH_ARB_ROUND_ROBIN_EN
    logic [PW-1:0]       rr_ptr_reg;
    logic [PW-1:0]       cand;
`endif

    // Pick this cycle's winner, build the one-hot grant and the winning address.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        gnt       = '0;
        win_addr  = '0;
`ifdef GLYPH_ARB_ROUND_ROBIN_EN
        cand      = '0;
        // Walk the ring starting just past the last granted requester.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr_reg + PW'(1) + PW'(k);
            if (cand >= PW'(NUM_REQ))
                cand = cand - PW'(NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_valid && cand == PW'(i) && req_valid[i]) begin
                    win_valid = 1'b1;
                    win_id    = PW'(i);
                end
            end
        end
`else
        // Scan downwards so the lowest requesting index is the last to stick.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_valid = 1'b1;
                win_id    = PW'(i);
            end
        end
`endif
        if (!en || !rst_n)
            win_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = win_valid && (win_id == PW'(i));
            if (gnt[i])
                win_addr = req_addr[i*AW +: AW];
        end
    end

    // Number of requests pending this cycle, for contention accounting.
    always_comb begin
        req_pop = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_pop = req_pop + PW'(req_valid[i]);
    end

    // ROM address register, tag pipeline, response pulses and conflict counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr_reg     <= '0;
            tag_valid_reg    <= '0;
            rsp_valid_reg    <= '0;
            conflict_cnt_reg <= '0;
            for (int s = 0; s < DEPTH; s++)
                tag_id_reg[s] <= '0;
        end else begin
            if (win_valid)
                rom_addr_reg <= win_addr;
            // Idle cycles push a bubble so latency stays fixed.
            tag_valid_reg <= {tag_valid_reg[DEPTH-2:0], win_valid};
            tag_id_reg[0] <= win_id;
            for (int s = 1; s < DEPTH; s++)
                tag_id_reg[s] <= tag_id_reg[s-1];
            for (int i = 0; i < NUM_REQ; i++)
                rsp_valid_reg[i] <= tag_valid_reg[DEPTH-1] && (tag_id_reg[DEPTH-1] == PW'(i));
            if (en && req_pop >= PW'(2) && conflict_cnt_reg != 16'hFFFF)
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

`ifdef GLYPH_ARB_ROUND_ROBIN_EN
    // Round-robin pointer remembers the last requester actually granted.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr_reg <= PW'(NUM_REQ - 1);
        else if (win_valid)
            rr_ptr_reg <= win_id;
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            logic [DW-1:0] slot_reg;
            // Capture the returning row only when the tag names this slot.
            always_ff @(posedge clk) begin
                if (!rst_n)
                    slot_reg <= '0;
                else if (tag_valid_reg[DEPTH-1] && tag_id_reg[DEPTH-1] == PW'(gi))
                    slot_reg <= rom_dout;
            end
            assign rsp_data[gi*DW +: DW] = slot_reg;
        end
    endgenerate

    assign rom_addr     = rom_addr_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign conflict_cnt = conflict_cnt_reg;
endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Self-checking bench for glyph_rom_arbiter. A transaction-level model (expected
// responses queued with their due cycle) predicts every output each cycle.
module tb_glyph_rom_arbiter;
    localparam int NUM_REQ = 2;
    localparam int AW      = 12;
    localparam int DW      = 12;
    localparam int ROM_LAT = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    gnt;
    logic [AW-1:0]         rom_addr;
    logic [DW-1:0]         rom_dout;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ*DW-1:0] rsp_data;
    logic [15:0]           conflict_cnt;

    glyph_rom_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_addr(req_addr),
        .gnt(gnt), .rom_addr(rom_addr), .rom_dout(rom_dout), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // ROM stand-in: contents are addr ^ 12'hFFF, read latency ROM_LAT.
    logic [DW-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr ^ 12'hFFF;
        for (int s = 1; s < ROM_LAT; s++)
            rom_pipe[s] <= rom_pipe[s-1];
    end
    assign rom_dout = rom_pipe[ROM_LAT-1];

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          pend[$];
    logic [DW-1:0] exp_slot [NUM_REQ];
    logic [AW-1:0] exp_rom_addr;
    int            exp_cnt;
    int            rr_last;
    int            cyc;
    int            last_w;
    int            rsp_seen [NUM_REQ];
    bit            verbose;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_slot[i] = '0;
            rsp_seen[i] = 0;
        end
        exp_rom_addr = '0;
        exp_cnt      = 0;
        rr_last      = NUM_REQ - 1;
    endtask

    // Requester the arbitration rule says should win right now, or -1.
    function automatic int model_winner();
        if (!rst_n || !en) return -1;
`ifdef GLYPH_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NUM_REQ; k++)
            if (req_valid[(rr_last + k) % NUM_REQ]) return (rr_last + k) % NUM_REQ;
`else
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i]) return i;
`endif
        return -1;
    endfunction

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic [NUM_REQ-1:0]    eg;
        logic [NUM_REQ-1:0]    erv;
        logic [NUM_REQ*DW-1:0] edata;
        int                    w;
        @(negedge clk);
        w  = model_winner();
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        erv = '0;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            erv[pend[0].id]      = 1'b1;
            exp_slot[pend[0].id] = pend[0].data;
            if (verbose)
                $display("[TB] cycle %0d: response slot %0d data %h", cyc, pend[0].id, pend[0].data);
            void'(pend.pop_front());
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            edata[i*DW +: DW] = exp_slot[i];
            if (rsp_valid[i]) rsp_seen[i]++;
        end
        check("gnt", 64'(gnt), 64'(eg));
        check("rsp_valid", 64'(rsp_valid), 64'(erv));
        check("rsp_data", 64'(rsp_data), 64'(edata));
        check("rom_addr", 64'(rom_addr), 64'(exp_rom_addr));
        check("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
        last_w = w;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (w >= 0) begin
                pend.push_back('{cyc + ROM_LAT + 2, w, req_addr[w*AW +: AW] ^ 12'hFFF});
                exp_rom_addr = req_addr[w*AW +: AW];
                rr_last      = w;
            end
            if (en && $countones(req_valid) >= 2 && exp_cnt < 65535)
                exp_cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        cycle();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        verbose   = 1'b1;
        cyc       = 0;
        last_w    = -1;
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;

        // Reset state, then a single request from slot 0.
        cycle();
        req_valid = 2'b01;
        req_addr[0 +: AW] = 12'h410;
        cyc = 0;
        cycle();
        req_valid = '0;
        repeat (4) cycle();
        check("single_slot0", 64'(rsp_data[0 +: DW]), 64'h0BEF);
        check("single_slot1", 64'(rsp_data[DW +: DW]), 64'h0);

        // Contention: both requesting for 8 cycles.
        do_reset();
        req_valid = 2'b11;
        req_addr  = {12'h310, 12'h300};
        repeat (8) cycle();
        req_valid = '0;
        repeat (4) cycle();
        check("contention_cnt", 64'(conflict_cnt), 64'd8);
`ifdef GLYPH_ARB_ROUND_ROBIN_EN
        check("rr_slot1", 64'(rsp_data[DW +: DW]), 64'h0CEF);
        check("rr_seen0", 64'(rsp_seen[0]), 64'd4);
        check("rr_seen1", 64'(rsp_seen[1]), 64'd4);
`else
        check("fp_slot1", 64'(rsp_data[DW +: DW]), 64'h0);
        check("fp_seen0", 64'(rsp_seen[0]), 64'd8);
`endif

        // Back-to-back plus bubble: grants in cycles 0, 1 and 3.
        do_reset();
        req_addr  = {12'h222, 12'h111};
        req_valid = 2'b01; cycle();
        req_valid = 2'b10; cycle();
        req_valid = 2'b00; cycle();
        req_valid = 2'b01; req_addr[0 +: AW] = 12'h555; cycle();
        req_valid = 2'b00;
        repeat (5) cycle();

        // en drops after a grant: response still arrives, no new grants.
        do_reset();
        req_valid = 2'b01; req_addr[0 +: AW] = 12'h0A5;
        cycle();
        en = 1'b0; req_valid = 2'b11;
        repeat (5) cycle();
        en = 1'b1; req_valid = '0;
        cycle();

        // Reset one cycle after a grant: the read is discarded.
        do_reset();
        req_valid = 2'b10; req_addr[AW +: AW] = 12'h7C3;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; req_valid = '0;
        repeat (4) cycle();
        check("post_reset_seen1", 64'(rsp_seen[1]), 64'd0);

        // Randomised traffic; requests held until the model says granted.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || last_w == i) begin
                    req_valid[i] = ($urandom % 3) == 0;
                    if (req_valid[i]) req_addr[i*AW +: AW] = AW'($urandom_range(0, 4095));
                end
            end
            en = ($urandom % 5) != 0;
            cycle();
        end
        en = 1'b1; req_valid = '0;
        repeat (5) cycle();

        // Saturation of the conflict counter.
        verbose = 1'b0;
        do_reset();
        req_valid = 2'b11;
        repeat (65540) cycle();
        check("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
        repeat (3) cycle();
        check("sat_hold", 64'(conflict_cnt), 64'hFFFF);
        req_valid = '0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
